splash_controller: RTL and testbench
====================================

SPLASH_CONTROLLER -- requirements
Module: splash_controller

Interface
REQ-001 The module SHALL expose parameter SPRITE_SIZE, default 50, giving the splash sprite edge length in pixels.
REQ-002 The module SHALL expose parameter HOLD_FRAMES, default 30, giving the number of frames a splash stays visible.
REQ-003 The module SHALL expose parameter TRANSPARENT_COLOR, default 12'hF0F, giving the sprite color key treated as see-through.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 x  input  10  current VGA scan column, 0-639.
REQ-007 y  input  9  current VGA scan row, 0-479.
REQ-008 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-009 hit  input  1  one-cycle pulse: fruit sliced, splash requested.
REQ-010 hit_x  input  10  top-left splash column, sampled when hit=1.
REQ-011 hit_y  input  9  top-left splash row, sampled when hit=1.
REQ-012 sprite_x  output  10  registered splash column, drives the sprite image lookup.
REQ-013 sprite_y  output  9  registered splash row, drives the sprite image lookup.
REQ-014 sprite_color  input  12  sprite pixel from the image lookup, valid 2 cycles after x/y.
REQ-015 bg_color  input  12  background pixel, aligned to the same cycle as sprite_color.
REQ-016 rgb  output  12  registered composited pixel.
REQ-017 active  output  1  high while state is SHOW.

Function
REQ-018 The state machine SHALL have states IDLE, ARMED and SHOW.
REQ-019 A hit SHALL set a pending flag and latch clamped coordinates; the last hit before a frame_start wins.
REQ-020 Clamp rules: latched x = min(hit_x, 640-SPRITE_SIZE); latched y = min(hit_y, 480-SPRITE_SIZE).
REQ-021 IDLE with pending set SHALL go to ARMED on the next cycle.
REQ-022 ARMED on frame_start SHALL load sprite_x/sprite_y from the latch, set frame counter to HOLD_FRAMES, clear pending and enter SHOW.
REQ-023 SHOW on frame_start with pending set SHALL reload coordinates, reload counter to HOLD_FRAMES, clear pending and stay in SHOW.
REQ-024 SHOW on frame_start with pending clear SHALL go to IDLE with counter 0 if counter==1; otherwise it SHALL decrement the counter.
REQ-025 sprite_x/sprite_y SHALL change only on frame_start, so no mid-frame tearing occurs.
REQ-026 Simultaneous hit and frame_start: frame_start SHALL act on the pre-existing pending value, and the new hit SHALL become pending for the next frame_start.
REQ-027 in_window = active AND x>=sprite_x AND x<sprite_x+SPRITE_SIZE AND y>=sprite_y AND y<sprite_y+SPRITE_SIZE; sums SHALL be computed 1 bit wider, with no wrap.
REQ-028 in_window SHALL be delayed through two registers to align with sprite_color.
REQ-029 rgb SHALL be registered as sprite_color when delayed in_window=1 and sprite_color!=TRANSPARENT_COLOR, else bg_color.
REQ-030 Latency from x/y to rgb SHALL be 3 cycles; the pipeline SHALL advance every cycle, with no stall.
REQ-031 A splash SHALL be visible for exactly HOLD_FRAMES full frames after arming.

Reset
REQ-032 On resetn=0, asynchronously: state=IDLE, pending=0, counter=0, latched coordinates=0, sprite_x=0, sprite_y=0, both in_window delay registers=0, rgb=0, active=0.
REQ-033 Reset asserted mid-SHOW SHALL drop active within the same cycle and discard any pending hit.
REQ-034 After resetn rises, the first hit SHALL be handled as in REQ-019..REQ-022.

Verification
REQ-035 Scenario: hit at (100,200), then frame_start -> active=1, sprite_x=100, sprite_y=200; active stays 1 for 30 frame_start pulses and falls on the 30th.
REQ-036 Scenario: hit_x=630, hit_y=470 -> sprite_x=590, sprite_y=430 after arming.
REQ-037 Scenario: during SHOW, scan x=120,y=210 with sprite_color=12'h0A0, bg_color=12'h333 -> rgb=12'h0A0 three cycles later; with sprite_color=12'hF0F -> rgb=12'h333; at x=150 -> rgb=12'h333.
REQ-038 Scenario: hit coincident with frame_start while IDLE -> no SHOW that frame; SHOW begins at the following frame_start.
REQ-039 Scenario: second hit at (300,100) during frame 10 of SHOW -> coordinates move only at the next frame_start, and the counter restarts at 30.
REQ-040 Scenario: resetn pulsed low mid-SHOW -> active=0 and rgb=0 immediately; the pending hit is lost.

Source files
------------

// File: rtl/splash_controller.sv
// Splash sprite controller: latches a clamped hit position, shows the sprite for
// HOLD_FRAMES frames, and composites it over the background with a 3-cycle pipeline.
module splash_controller #(
  parameter int          SPRITE_SIZE       = 50,
  parameter int          HOLD_FRAMES       = 30,
  parameter logic [11:0] TRANSPARENT_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        frame_start,
  input  logic        hit,
  input  logic [9:0]  hit_x,
  input  logic [8:0]  hit_y,
  output logic [9:0]  sprite_x,
  output logic [8:0]  sprite_y,
  input  logic [11:0] sprite_color,
  input  logic [11:0] bg_color,
  output logic [11:0] rgb,
  output logic        active
);

  // state | meaning
  // IDLE  | no splash on screen, waiting for a pending hit
  // ARMED | hit pending, waiting for frame_start to begin showing
  // SHOW  | splash visible, counting down frames

  localparam int              CW    = $clog2(HOLD_FRAMES + 1);
  localparam logic [9:0]      MAX_X = 10'(640 - SPRITE_SIZE);
  localparam logic [8:0]      MAX_Y = 9'(480 - SPRITE_SIZE);
  localparam logic [CW-1:0]   HOLD  = CW'(HOLD_FRAMES);
  localparam logic [10:0]     SZ_X  = 11'(SPRITE_SIZE);
  localparam logic [9:0]      SZ_Y  = 10'(SPRITE_SIZE);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t        state_q;
  logic          pending_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    lat_x_q, sprite_x_q, lat_x_d;
  logic [8:0]    lat_y_q, sprite_y_q, lat_y_d;
  logic          active_q;
  logic          in_window_d, win1_q, win2_q;
  logic [11:0]   rgb_q, rgb_d;

  always_comb begin
    lat_x_d = (hit_x > MAX_X) ? MAX_X : hit_x;
    lat_y_d = (hit_y > MAX_Y) ? MAX_Y : hit_y;
    // one bit wider so a sprite near the right/bottom edge never wraps
    in_window_d = active_q
                  && ({1'b0, x} >= {1'b0, sprite_x_q})
                  && ({1'b0, x} <  ({1'b0, sprite_x_q} + SZ_X))
                  && ({1'b0, y} >= {1'b0, sprite_y_q})
                  && ({1'b0, y} <  ({1'b0, sprite_y_q} + SZ_Y));
    rgb_d = (win2_q && (sprite_color != TRANSPARENT_COLOR)) ? sprite_color : bg_color;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      lat_x_q    <= '0;
      lat_y_q    <= '0;
      sprite_x_q <= '0;
      sprite_y_q <= '0;
      active_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) state_q <= ARMED;
        end
        ARMED: begin
          if (frame_start) begin
            sprite_x_q <= lat_x_q;
            sprite_y_q <= lat_y_q;
            cnt_q      <= HOLD;
            pending_q  <= 1'b0;
            state_q    <= SHOW;
            active_q   <= 1'b1;
          end
        end
        SHOW: begin
          if (frame_start) begin
            if (pending_q) begin
              sprite_x_q <= lat_x_q;
              sprite_y_q <= lat_y_q;
              cnt_q      <= HOLD;
              pending_q  <= 1'b0;
            end else if (cnt_q == CW'(1)) begin
              cnt_q    <= '0;
              state_q  <= IDLE;
              active_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
      // a new hit overrides the clear above, so it waits for the next frame_start
      if (hit) begin
        pending_q <= 1'b1;
        lat_x_q   <= lat_x_d;
        lat_y_q   <= lat_y_d;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win1_q <= 1'b0;
      win2_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      win1_q <= in_window_d;
      win2_q <= win1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign sprite_x = sprite_x_q;
  assign sprite_y = sprite_y_q;
  assign active   = active_q;
  assign rgb      = rgb_q;

endmodule

// File: tb/tb_splash_controller.sv
// Directed bench for splash_controller: arming, hold count, clamping, retrigger,
// coincident hit/frame_start, compositing and asynchronous reset.
module tb_splash_controller;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        frame_start = 1'b0;
  logic        hit = 1'b0;
  logic [9:0]  hit_x = '0;
  logic [8:0]  hit_y = '0;
  logic [9:0]  sprite_x;
  logic [8:0]  sprite_y;
  logic [11:0] sprite_color = '0;
  logic [11:0] bg_color = '0;
  logic [11:0] rgb;
  logic        active;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  // reference of what the sprite window should be
  int m_sx = 0, m_sy = 0;
  bit m_act = 1'b0;

  splash_controller dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .frame_start(frame_start),
    .hit(hit), .hit_x(hit_x), .hit_y(hit_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_color(sprite_color), .bg_color(bg_color), .rgb(rgb), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fs();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic do_hit(input int hx, input int hy);
    @(negedge clk) begin hit = 1'b1; hit_x = 10'(hx); hit_y = 9'(hy); end
    @(negedge clk) hit = 1'b0;
    @(negedge clk);
  endtask

  function automatic bit inwin(input int px, input int py);
    return m_act && px >= m_sx && px < m_sx + 50 && py >= m_sy && py < m_sy + 50;
  endfunction

  task automatic pix(input string tag, input int px, input int py, input int sc, input int bg);
    logic [31:0] e;
    e = (inwin(px, py) && sc != 'hF0F) ? 32'(sc) : 32'(bg);
    sb.push_back(e);
    @(negedge clk) begin x = 10'(px); y = 9'(py); end
    @(negedge clk);
    @(negedge clk) begin sprite_color = 12'(sc); bg_color = 12'(bg); end
    @(negedge clk);
    chk(tag, 32'(rgb), sb.pop_front());
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_active", 32'(active), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_sx", 32'(sprite_x), 0);
    chk("rst_sy", 32'(sprite_y), 0);
    resetn = 1'b1;
    @(negedge clk);

    // basic arm and hold
    do_hit(100, 200);
    chk("armed_inactive", 32'(active), 0);
    fs();
    m_act = 1; m_sx = 100; m_sy = 200;
    chk("arm_active", 32'(active), 1);
    chk("arm_sx", 32'(sprite_x), 100);
    chk("arm_sy", 32'(sprite_y), 200);

    pix("pix_in", 120, 210, 'h0A0, 'h333);
    pix("pix_transp", 120, 210, 'hF0F, 'h333);
    pix("pix_right_edge", 150, 210, 'h0A0, 'h333);
    pix("pix_last_in", 149, 249, 'h0A0, 'h333);
    pix("pix_left_out", 99, 210, 'h0A0, 'h333);
    pix("pix_bottom_out", 120, 250, 'h0A0, 'h333);

    for (int k = 1; k < 30; k++) begin
      fs();
      chk("hold_active", 32'(active), 1);
    end
    fs();
    m_act = 0;
    chk("hold_end", 32'(active), 0);
    pix("pix_idle", 120, 210, 'h0A0, 'h333);

    // clamping near the bottom-right corner
    do_hit(630, 470);
    fs();
    m_act = 1; m_sx = 590; m_sy = 430;
    chk("clamp_sx", 32'(sprite_x), 590);
    chk("clamp_sy", 32'(sprite_y), 430);
    pix("pix_corner", 639, 479, 'h0A0, 'h333);

    // retrigger during frame 10
    for (int k = 0; k < 9; k++) fs();
    do_hit(300, 100);
    chk("retrig_no_tear_sx", 32'(sprite_x), 590);
    chk("retrig_no_tear_sy", 32'(sprite_y), 430);
    fs();
    m_sx = 300; m_sy = 100;
    chk("retrig_sx", 32'(sprite_x), 300);
    chk("retrig_sy", 32'(sprite_y), 100);
    for (int k = 1; k < 30; k++) begin
      fs();
      chk("retrig_hold", 32'(active), 1);
    end
    fs();
    m_act = 0;
    chk("retrig_end", 32'(active), 0);

    // hit coincident with frame_start while idle
    @(negedge clk) begin hit = 1'b1; frame_start = 1'b1; hit_x = 10'd50; hit_y = 9'd60; end
    @(negedge clk) begin hit = 1'b0; frame_start = 1'b0; end
    @(negedge clk);
    @(negedge clk);
    chk("coinc_no_show", 32'(active), 0);
    chk("coinc_sx_held", 32'(sprite_x), 300);
    fs();
    m_act = 1; m_sx = 50; m_sy = 60;
    chk("coinc_show", 32'(active), 1);
    chk("coinc_sx", 32'(sprite_x), 50);
    chk("coinc_sy", 32'(sprite_y), 60);

    // asynchronous reset mid-SHOW with a pending hit
    pix("pix_pre_reset", 60, 70, 'h0A0, 'h333);
    do_hit(400, 300);
    chk("pre_reset_rgb", 32'(rgb), 'h0A0);
    #2 resetn = 1'b0;
    #1;
    m_act = 0; m_sx = 0; m_sy = 0;
    chk("reset_active", 32'(active), 0);
    chk("reset_rgb", 32'(rgb), 0);
    chk("reset_sx", 32'(sprite_x), 0);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    fs();
    chk("pending_lost1", 32'(active), 0);
    fs();
    chk("pending_lost2", 32'(active), 0);

    do_hit(10, 20);
    fs();
    m_act = 1; m_sx = 10; m_sy = 20;
    chk("post_reset_active", 32'(active), 1);
    chk("post_reset_sx", 32'(sprite_x), 10);
    chk("post_reset_sy", 32'(sprite_y), 20);
    pix("pix_post_reset", 59, 69, 'h00F, 'h333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
